// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WPTR,
      ST_WPTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_t;

   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_target_line_cond.sv
// Conditions one raw I2C line: 2-FF synchronizer, optional 3-sample glitch filter, edge detect.
// Build option: I2C_TARGET_GLITCH_FILTER_EN adds the filter (2 extra cycles of latency).
module i2c_line_cond (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [1:0] sync;
   logic       prev;

   // Idle I2C lines float high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], pin};
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] samp;
   logic [2:0] window;
   logic       filt;

   assign window = {samp, sync[1]};

   always_comb begin
      level = filt;
      if (&window)       level = 1'b1;
      else if (~|window) level = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp <= 2'b11;
         filt <= 1'b1;
      end else begin
         samp <= {samp[0], sync[1]};
         filt <= level;
      end
   end
`else
   assign level = sync[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b1;
      else     prev <= level;
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target giving an external controller read/write access to 2^AW 8-bit registers.
// Build option: I2C_TARGET_GLITCH_FILTER_EN enables the SCL/SDA glitch filter.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] ADDR = 7'h50,
   parameter int         AW   = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_scl,
   input  logic          i_sda,
   output logic          o_sda_ld,
   output logic [AW-1:0] o_reg_addr,
   output logic          o_wr_stb,
   output logic [7:0]    o_wr_data,
   input  logic [7:0]    i_rd_data,
   output logic          o_rd_stb,
   output logic          o_busy
);
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;
   logic start, stop;

   state_t        state, state_n;
   logic [2:0]    cnt, cnt_n;
   logic [6:0]    shreg, sh_n;
   logic [7:0]    tx, tx_n;
   logic [AW-1:0] ptr, ptr_n;
   logic          rw, rw_n;
   logic          sda_ld, sda_ld_n;
   logic          busy, busy_n;
   logic          wr_stb, wr_stb_n;
   logic [7:0]    wr_data, wr_data_n;
   logic          rd_stb, rd_stb_n;
   logic [7:0]    rx_byte;

   i2c_line_cond u_scl (
      .clk(i_clk), .rst(i_rst), .pin(i_scl),
      .level(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_cond u_sda (
      .clk(i_clk), .rst(i_rst), .pin(i_sda),
      .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   // An SDA edge coinciding with an SCL edge is data, not a bus condition.
   assign start   = sda_fall & scl & ~scl_rise;
   assign stop    = sda_rise & scl & ~scl_rise;
   assign rx_byte = {shreg, sda};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         tx      <= '0;
         ptr     <= '0;
         rw      <= 1'b0;
         sda_ld  <= 1'b0;
         busy    <= 1'b0;
         wr_stb  <= 1'b0;
         wr_data <= '0;
         rd_stb  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         shreg   <= sh_n;
         tx      <= tx_n;
         ptr     <= ptr_n;
         rw      <= rw_n;
         sda_ld  <= sda_ld_n;
         busy    <= busy_n;
         wr_stb  <= wr_stb_n;
         wr_data <= wr_data_n;
         rd_stb  <= rd_stb_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      sh_n      = shreg;
      tx_n      = tx;
      ptr_n     = ptr;
      rw_n      = rw;
      sda_ld_n  = sda_ld;
      busy_n    = busy;
      wr_stb_n  = 1'b0;
      wr_data_n = wr_data;
      rd_stb_n  = 1'b0;

      if (start) begin
         state_n  = ST_ADDR;
         cnt_n    = '0;
         sda_ld_n = 1'b0;
      end else if (stop) begin
         state_n  = ST_IDLE;
         sda_ld_n = 1'b0;
         busy_n   = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_WPTR, ST_WDATA: begin
               if (scl_rise) begin
                  sh_n  = rx_byte[6:0];
                  cnt_n = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (state == ST_ADDR) begin
                        if (rx_byte[7:1] == ADDR && rx_byte[7:1] != 7'h00) begin
                           state_n = ST_ADDR_ACK;
                           busy_n  = 1'b1;
                           rw_n    = rx_byte[0];
                        end else begin
                           state_n = ST_IGNORE;
                           busy_n  = 1'b0;
                        end
                     end else if (state == ST_WPTR) begin
                        ptr_n   = rx_byte[AW-1:0];
                        state_n = ST_WPTR_ACK;
                     end else begin
                        wr_stb_n  = 1'b1;
                        wr_data_n = rx_byte;
                        state_n   = ST_WDATA_ACK;
                     end
                  end
               end
            end

            // First SCL fall drives the ACK, the second one releases it and moves on.
            ST_ADDR_ACK, ST_WPTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_ld) begin
                     sda_ld_n = ~I2C_ACK;
                  end else begin
                     sda_ld_n = 1'b0;
                     cnt_n    = '0;
                     if (state == ST_ADDR_ACK) begin
                        if (rw == I2C_RW_READ) begin
                           tx_n     = i_rd_data;
                           rd_stb_n = 1'b1;
                           sda_ld_n = ~i_rd_data[7];
                           state_n  = ST_RDATA;
                        end else begin
                           state_n = ST_WPTR;
                        end
                     end else if (state == ST_WPTR_ACK) begin
                        state_n = ST_WDATA;
                     end else begin
                        ptr_n   = ptr + PTR_ONE;
                        state_n = ST_WDATA;
                     end
                  end
               end
            end

            // cnt wraps to 0 after the 8th rise, marking the end of the byte.
            ST_RDATA: begin
               if (scl_rise) begin
                  cnt_n = cnt + 3'd1;
               end else if (scl_fall) begin
                  if (cnt == 3'd0) begin
                     sda_ld_n = 1'b0;
                     state_n  = ST_RACK;
                  end else begin
                     tx_n     = {tx[6:0], 1'b0};
                     sda_ld_n = ~tx[6];
                  end
               end
            end

            // Pointer moves on the ACK rise so i_rd_data is settled by the following fall.
            ST_RACK: begin
               if (scl_rise) begin
                  if (sda == I2C_ACK) ptr_n = ptr + PTR_ONE;
                  else                state_n = ST_IGNORE;
               end else if (scl_fall) begin
                  tx_n     = i_rd_data;
                  rd_stb_n = 1'b1;
                  sda_ld_n = ~i_rd_data[7];
                  cnt_n    = '0;
                  state_n  = ST_RDATA;
               end
            end

            default: sda_ld_n = 1'b0;
         endcase
      end
   end

   assign o_sda_ld   = sda_ld;
   assign o_reg_addr = ptr;
   assign o_wr_stb   = wr_stb;
   assign o_wr_data  = wr_data;
   assign o_rd_stb   = rd_stb;
   assign o_busy     = busy;

endmodule

// File: doc/i2c_target.md
# i2c_target

Synthesizable I2C target (responder) that lets an external I2C controller read and write a small bank of 8-bit registers. The bank is exposed on a simple local strobe interface. It is the far end of the open-drain I2C port the CPU bit-bangs through its GPIO lines, and it sits beside the bus interconnect. It runs on the system clock and oversamples SCL and SDA, so it needs no second clock domain.

## Interface
- `ADDR`, default 7'h50: 7-bit target address the block answers to.
- `AW`, default 4: register-pointer width; the block addresses 2^AW registers.
- `i_clk`  in  1: system clock (80 MHz); the only clock.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_scl`  in  1: raw SCL pin level, asynchronous.
- `i_sda`  in  1: raw SDA pin level, asynchronous.
- `o_sda_ld`  out  1: 1 pulls SDA low; 0 releases SDA to float high.
- `o_reg_addr`  out  AW: current register pointer.
- `o_wr_stb`  out  1: one-cycle write strobe.
- `o_wr_data`  out  8: write data, valid while `o_wr_stb` is high.
- `i_rd_data`  in  8: register contents at `o_reg_addr`; combinational and valid in the same cycle.
- `o_rd_stb`  out  1: one-cycle pulse when `i_rd_data` is latched for transmission.
- `o_busy`  out  1: high from an address match until the next STOP or non-matching START.

## Operation
- **Input conditioning:** SCL and SDA each pass through a 2-FF synchronizer. Rise and fall detection compares each synchronized level with its previous-cycle value.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both take priority over every state and abort the current byte.
  - START, including a repeated START, goes to ADDR.
  - STOP goes to IDLE.
- **Bit handling:** data bits shift in MSB-first on SCL rise. A 3-bit counter counts bits 0..7.
- **States:** IDLE, ADDR, ADDR_ACK, WPTR, WPTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- **ADDR:** after 8 bits, if byte[7:1] equals ADDR, go to ADDR_ACK and set `o_busy`. Otherwise go to IGNORE with SDA released.
- **ACK driving:** in every `*_ACK` state, assert `o_sda_ld` on the SCL fall that follows bit 8. Release it on the next SCL fall.
- **Leaving ADDR_ACK:**
  - R/W=0: go to WPTR.
  - R/W=1: go to RDATA. On the SCL fall that ends the ACK, latch `i_rd_data` into the TX shifter and pulse `o_rd_stb`.
- **Write path:**
  - WPTR: the received byte's low AW bits load the pointer, then ACK.
  - WDATA: after 8 bits, pulse `o_wr_stb` with `o_wr_data` = byte at the current `o_reg_addr`, ACK, then increment the pointer.
- **Read path:**
  - RDATA: drive `o_sda_ld` = ~txbit on each SCL fall.
  - After 8 bits, release SDA and go to RACK.
  - RACK samples SDA on SCL rise:
    - Controller ACK (0): increment the pointer, load the next byte with an `o_rd_stb` pulse on SCL fall, and return to RDATA.
    - Controller NACK (1): go to IGNORE.
- **Pointer rules:** the pointer increments modulo 2^AW, so 2^AW−1 wraps to 0. The pointer is retained across STOP and repeated START, which supports the write-pointer, repeated START, read sequence.
- **IGNORE:** `o_sda_ld` stays 0 and the block waits for START or STOP.
- **Unsupported:** general call and 10-bit addressing are ignored (IGNORE).

## Timing
- **Reset values:** `o_sda_ld`=0, `o_wr_stb`=0, `o_wr_data`=0, `o_rd_stb`=0, `o_reg_addr`=0, `o_busy`=0, state=IDLE.
- **Reset mid-transfer:** SDA is released immediately, asynchronously.
- **Input latency:** pin to synchronized edge is 2 cycles, or 4 with the filter compiled in.
- **Output latency:** `o_sda_ld` changes 1 cycle after the detected SCL fall, well within the tHD;DAT window.
- **Minimum bus timing:** SCL high and low each ≥ 4 `i_clk` cycles, or ≥ 8 with the filter. 400 kHz at 80 MHz leaves a large margin.
- **Simultaneous SDA and SCL edges** in the same cycle are treated as data, not START or STOP.
- **Strobes:** `o_wr_stb` and `o_rd_stb` are never high in the same cycle. Each is exactly one cycle wide.

## Configuration
- Macro `I2C_TARGET_GLITCH_FILTER_EN`.
- **Defined:** each synchronized line feeds a 3-sample shift register. The filtered level changes only when all 3 samples agree, so pulses ≤ 2 cycles are rejected. This adds 2 cycles of latency.
- **Undefined:** the 2-FF synchronizer output is used directly.

## Structure
- **Shared package:** state enum, `I2C_RW_READ`=1'b1, ACK level constant (1'b0).
- **Sub-module:** `i2c_line_cond` holds the synchronizer, optional filter and rise/fall detect. It is instantiated twice, once for SCL and once for SDA.

## Test plan
- **Write two registers:** START, 0xA0, 0x03, 0xA5, 0x5A, STOP → target ACKs all 4 bytes; `o_wr_stb` pulses with addr 3/0xA5 then addr 4/0x5A; `o_busy` drops at STOP.
- **Pointer then read:** START, 0xA0, 0x07, repeated START, 0xA1, controller ACK, controller NACK, STOP, with `i_rd_data` = {4'h0, addr} → bytes 0x07 and 0x08 on SDA; 2 `o_rd_stb` pulses.
- **Address mismatch:** START, 0xA2 (address 0x51), 0x11, STOP → `o_sda_ld` never asserted, no strobes, `o_busy` stays 0.
- **Pointer wrap:** pointer 0x0F, write 3 bytes → writes land at 0xF, 0x0, 0x1.
- **Reset mid-transfer:** assert `i_rst` during the ACK of the second byte → `o_sda_ld`=0 in the same cycle; the next START/0xA0 is ACKed normally.
- **Glitch filter (macro defined):** a 1-cycle SCL high glitch inside a low phase → bit count unchanged and the byte is received correctly. With the macro undefined, the same glitch corrupts the byte.
